// File: rtl/fft_pkg.sv
// Shared definitions for the FIFO slice: default word width, legal depth
// range, a constant-foldable clog2 and the per-cycle operation encoding.
package fft_pkg;

  localparam int FIFO_WIDTH_DEF = 17;
  localparam int FIFO_DEPTH_MIN = 1;
  localparam int FIFO_DEPTH_MAX = 1024;

  // What the storage does on a given edge once acceptance rules are applied.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_WR   = 2'b01,
    OP_RD   = 2'b10,
    OP_RW   = 2'b11
  } fifo_op_e;

  // Ceiling log2; clog2(1) = 0. Written as a bounded loop so it folds at
  // elaboration for parameter arithmetic.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Collapse accepted write/read strobes into one operation code.
  function automatic fifo_op_e fifo_op(input logic wr, input logic rd);
    fifo_op_e op;
    case ({rd, wr})
      2'b01:   op = OP_WR;
      2'b10:   op = OP_RD;
      2'b11:   op = OP_RW;
      default: op = OP_IDLE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Modulo-DEPTH pointer: advances on inc, wraps DEPTH-1 -> 0, synchronous
// clear has priority over inc, asynchronous active-low reset to zero.
module fifo_ptr
  import fft_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] ptr
);

  logic [AW-1:0] ptr_q;
  logic [AW-1:0] ptr_d;

  // Next pointer: flush to zero, else step with wrap at the last slot.
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      if (ptr_q == AW'(DEPTH - 1)) ptr_d = '0;
      else                         ptr_d = ptr_q + AW'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_n.sv
// Synchronous FIFO with show-ahead read port, flip-flop storage cleared by
// reset, arbitrary depth 1..1024, and sticky overflow/underflow flags.
module fifo_n
  import fft_pkg::*;
#(
  parameter  int WIDTH = FIFO_WIDTH_DEF,
  parameter  int DEPTH = 32,
  localparam int AW    = (clog2(DEPTH) > 1) ? clog2(DEPTH) : 1,
  localparam int CW    = clog2(DEPTH + 1)
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             w_en,
  input  logic             r_en,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             ovf,
  output logic             udf
);

  if (DEPTH < FIFO_DEPTH_MIN || DEPTH > FIFO_DEPTH_MAX) begin : g_depth_chk
    $error("fifo_n: DEPTH outside legal range");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] head;
  logic             full_w, empty_w;
  logic             wr_acc, rd_acc, wr_fire;
  fifo_op_e         op;

  // Flags come from the registered count only, so they never depend
  // combinationally on this cycle's requests.
  assign full_w  = (count_q == CW'(DEPTH));
  assign empty_w = (count_q == '0);

  // A full FIFO still takes a write when the same cycle pops the head,
  // because the popped slot is the one being refilled.
  assign wr_acc  = w_en & (~full_w | r_en);
  assign rd_acc  = r_en & ~empty_w;
  assign wr_fire = wr_acc & ~clr;

  fifo_ptr #(.DEPTH(DEPTH), .AW(AW)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (wr_acc),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.DEPTH(DEPTH), .AW(AW)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (rd_acc),
    .ptr   (rd_ptr)
  );

  // Storage: every word is a flop so reset can wipe stale data; only the
  // slot under the write pointer loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_fire && (wr_ptr == AW'(i))) mem_q[i] <= data_in;
      end
    end
  end

  // Head-of-queue mux; compared slot by slot so non-power-of-2 depths never
  // index past the array.
  always_comb begin
    head = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_ptr == AW'(i)) head = mem_q[i];
    end
  end

  // Occupancy and sticky error flags; flush clears them and ignores requests.
  always_comb begin
    op      = fifo_op(wr_acc, rd_acc);
    count_d = count_q;
    ovf_d   = ovf_q | (w_en & full_w & ~r_en);
    udf_d   = udf_q | (r_en & empty_w);
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      case (op)
        OP_WR:   count_d = count_q + CW'(1);
        OP_RD:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign data_out = rd_acc ? head : '0;
  assign full     = full_w;
  assign empty    = empty_w;
  assign count    = count_q;
  assign ovf      = ovf_q;
  assign udf      = udf_q;

endmodule

// File: tb/tb_fifo_n.sv
// Bench for fifo_n: four instances (DEPTH 32, 4, 3, 1) against a queue-style
// reference model, directed scenarios with literal expectations, then
// randomized traffic.
module tb_fifo_n;
  import fft_pkg::*;

  localparam int N = 4;
  localparam int W = 17;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         clr   [N];
  logic         w_en  [N];
  logic         r_en  [N];
  logic [W-1:0] din   [N];
  logic [W-1:0] dout  [N];
  logic         full  [N];
  logic         empty [N];
  logic         ovf   [N];
  logic         udf   [N];
  logic [5:0]   cnt0;
  logic [2:0]   cnt1;
  logic [1:0]   cnt2;
  logic [0:0]   cnt3;

  fifo_n #(.WIDTH(W), .DEPTH(32)) u_d32 (
    .clk(clk), .rst_n(rst_n), .clr(clr[0]), .w_en(w_en[0]), .r_en(r_en[0]),
    .data_in(din[0]), .data_out(dout[0]), .full(full[0]), .empty(empty[0]),
    .count(cnt0), .ovf(ovf[0]), .udf(udf[0]));
  fifo_n #(.WIDTH(W), .DEPTH(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .clr(clr[1]), .w_en(w_en[1]), .r_en(r_en[1]),
    .data_in(din[1]), .data_out(dout[1]), .full(full[1]), .empty(empty[1]),
    .count(cnt1), .ovf(ovf[1]), .udf(udf[1]));
  fifo_n #(.WIDTH(W), .DEPTH(3)) u_d3 (
    .clk(clk), .rst_n(rst_n), .clr(clr[2]), .w_en(w_en[2]), .r_en(r_en[2]),
    .data_in(din[2]), .data_out(dout[2]), .full(full[2]), .empty(empty[2]),
    .count(cnt2), .ovf(ovf[2]), .udf(udf[2]));
  fifo_n #(.WIDTH(W), .DEPTH(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .clr(clr[3]), .w_en(w_en[3]), .r_en(r_en[3]),
    .data_in(din[3]), .data_out(dout[3]), .full(full[3]), .empty(empty[3]),
    .count(cnt3), .ovf(ovf[3]), .udf(udf[3]));

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: a circular list per instance with head index and size.
  logic [W-1:0] m_mem [N][32];
  int           m_head[N];
  int           m_cnt [N];
  bit           m_ovf [N];
  bit           m_udf [N];

  function automatic int dep(input int i);
    case (i)
      0:       return 32;
      1:       return 4;
      2:       return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int get_cnt(input int i);
    case (i)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      2:       return int'(cnt2);
      default: return int'(cnt3);
    endcase
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[D=%0d] t=%0t got %0h expected %0h", nm, dep(i), $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_head[i] = 0;
      m_cnt[i]  = 0;
      m_ovf[i]  = 1'b0;
      m_udf[i]  = 1'b0;
    end
  endtask

  // Apply one clock edge's worth of FIFO rules to every instance.
  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      int d;
      int c;
      int h;
      bit rd;
      bit wr;
      d = dep(i);
      c = m_cnt[i];
      h = m_head[i];
      if (clr[i]) begin
        m_cnt[i]  = 0;
        m_head[i] = 0;
        m_ovf[i]  = 1'b0;
        m_udf[i]  = 1'b0;
      end else begin
        rd = r_en[i] && (c > 0);
        wr = w_en[i] && ((c < d) || r_en[i]);
        if (w_en[i] && (c == d) && !r_en[i]) m_ovf[i] = 1'b1;
        if (r_en[i] && (c == 0))             m_udf[i] = 1'b1;
        if (wr) m_mem[i][(h + c) % d] = din[i];
        if (rd) m_head[i] = (h + 1) % d;
        m_cnt[i] = c + int'(wr) - int'(rd);
      end
    end
  endtask

  // Compare process: every falling edge, all outputs of all instances.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        logic [W-1:0] exp_do;
        exp_do = (r_en[i] && m_cnt[i] > 0) ? m_mem[i][m_head[i]] : '0;
        chk("data_out", i, 32'(dout[i]), 32'(exp_do));
        chk("count",    i, 32'(get_cnt(i)), 32'(m_cnt[i]));
        chk("full",     i, 32'(full[i]),  32'(m_cnt[i] == dep(i)));
        chk("empty",    i, 32'(empty[i]), 32'(m_cnt[i] == 0));
        chk("ovf",      i, 32'(ovf[i]),   32'(m_ovf[i]));
        chk("udf",      i, 32'(udf[i]),   32'(m_udf[i]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) begin
      clr[i]  = 1'b0;
      w_en[i] = 1'b0;
      r_en[i] = 1'b0;
      din[i]  = '0;
    end
  endtask

  task automatic set_in(input int i, input bit w, input bit r, input logic [W-1:0] d, input bit c);
    w_en[i] = w;
    r_en[i] = r;
    din[i]  = d;
    clr[i]  = c;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog t=%0t got timeout expected finish", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int wp;
    int rp;
    idle_all();
    rst_n = 1'b0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    #2;
    for (int i = 0; i < N; i++) begin
      chk("rst_empty", i, 32'(empty[i]), 32'd1);
      chk("rst_full",  i, 32'(full[i]),  32'd0);
      chk("rst_count", i, 32'(get_cnt(i)), 32'd0);
      chk("rst_dout",  i, 32'(dout[i]),  32'd0);
    end

    // In-order write then read, DEPTH=32.
    for (int k = 1; k <= 5; k++) begin
      set_in(0, 1'b1, 1'b0, W'(k), 1'b0);
      tick();
    end
    set_in(0, 1'b0, 1'b0, '0, 1'b0);
    #2 chk("d32_count5", 0, 32'(cnt0), 32'd5);
    for (int k = 1; k <= 5; k++) begin
      set_in(0, 1'b0, 1'b1, '0, 1'b0);
      #2 chk("d32_rd", 0, 32'(dout[0]), 32'(k));
      chk("d32_cnt", 0, 32'(cnt0), 32'(6 - k));
      tick();
    end
    set_in(0, 1'b0, 1'b0, '0, 1'b0);
    #2 chk("d32_empty", 0, 32'(empty[0]), 32'd1);

    // Overflow drop, DEPTH=4.
    for (int k = 0; k < 4; k++) begin
      set_in(1, 1'b1, 1'b0, W'(32'h100 + k), 1'b0);
      tick();
    end
    set_in(1, 1'b1, 1'b0, 17'h1FFFF, 1'b0);
    #2 chk("d4_full", 1, 32'(full[1]), 32'd1);
    tick();
    set_in(1, 1'b0, 1'b0, '0, 1'b0);
    #2 chk("d4_ovf", 1, 32'(ovf[1]), 32'd1);
    chk("d4_cnt", 1, 32'(cnt1), 32'd4);
    for (int k = 0; k < 4; k++) begin
      set_in(1, 1'b0, 1'b1, '0, 1'b0);
      #2 chk("d4_rd", 1, 32'(dout[1]), 32'h100 + k);
      tick();
    end
    set_in(1, 1'b0, 1'b0, '0, 1'b1);
    tick();

    // Full with simultaneous read/write across pointer wrap, DEPTH=4.
    for (int k = 0; k < 4; k++) begin
      set_in(1, 1'b1, 1'b0, W'(32'h200 + k), 1'b0);
      tick();
    end
    for (int k = 0; k < 8; k++) begin
      set_in(1, 1'b1, 1'b1, W'(32'h300 + k), 1'b0);
      #2 chk("d4_rw_dout", 1, 32'(dout[1]), (k < 4) ? 32'h200 + k : 32'h300 + k - 4);
      tick();
      chk("d4_rw_cnt", 1, 32'(cnt1), 32'd4);
      chk("d4_rw_ovf", 1, 32'(ovf[1]), 32'd0);
    end
    for (int k = 4; k < 8; k++) begin
      set_in(1, 1'b0, 1'b1, '0, 1'b0);
      #2 chk("d4_drain", 1, 32'(dout[1]), 32'h300 + k);
      tick();
    end
    set_in(1, 1'b0, 1'b0, '0, 1'b0);

    // Underflow then flush, DEPTH=32; write on empty with read set too.
    set_in(0, 1'b1, 1'b1, 17'h00077, 1'b0);
    #2 chk("udf_dout", 0, 32'(dout[0]), 32'd0);
    tick();
    set_in(0, 1'b0, 1'b0, '0, 1'b0);
    #2 chk("udf_set", 0, 32'(udf[0]), 32'd1);
    chk("udf_cnt1", 0, 32'(cnt0), 32'd1);
    set_in(0, 1'b1, 1'b1, 17'h00055, 1'b1);
    tick();
    set_in(0, 1'b0, 1'b0, '0, 1'b0);
    #2 chk("clr_udf", 0, 32'(udf[0]), 32'd0);
    chk("clr_cnt", 0, 32'(cnt0), 32'd0);

    // Mid-cycle asynchronous reset, DEPTH=3.
    for (int k = 0; k < 2; k++) begin
      set_in(2, 1'b1, 1'b0, W'(32'h40 + k), 1'b0);
      tick();
    end
    set_in(2, 1'b0, 1'b0, '0, 1'b0);
    #2 chk("d3_cnt2", 2, 32'(cnt2), 32'd2);
    rst_n = 1'b0;
    model_reset();
    #1 chk("d3_rst_empty", 2, 32'(empty[2]), 32'd1);
    chk("d3_rst_cnt", 2, 32'(cnt2), 32'd0);
    tick();
    rst_n = 1'b1;
    set_in(2, 1'b1, 1'b0, 17'h0000A, 1'b0);
    tick();
    set_in(2, 1'b0, 1'b1, '0, 1'b0);
    #2 chk("d3_after", 2, 32'(dout[2]), 32'h0000A);
    tick();
    set_in(2, 1'b0, 1'b0, '0, 1'b0);

    // Single-word FIFO, DEPTH=1.
    for (int k = 0; k < 4; k++) begin
      logic [W-1:0] v;
      v = (k % 2 == 0) ? 17'h15555 : 17'h0AAAA;
      set_in(3, 1'b1, 1'b0, v, 1'b0);
      tick();
      #2 chk("d1_full", 3, 32'(full[3]), 32'd1);
      chk("d1_nempty", 3, 32'(empty[3]), 32'd0);
      set_in(3, 1'b0, 1'b1, '0, 1'b0);
      #1 chk("d1_dout", 3, 32'(dout[3]), 32'(v));
      tick();
      #2 chk("d1_empty", 3, 32'(empty[3]), 32'd1);
    end
    set_in(3, 1'b0, 1'b0, '0, 1'b0);
    idle_all();
    tick();

    // Randomized traffic in blocks that lean toward filling or draining.
    for (int blk = 0; blk < 16; blk++) begin
      wp = (blk % 2 == 0) ? 80 : 30;
      rp = (blk % 2 == 0) ? 30 : 80;
      for (int cyc = 0; cyc < 200; cyc++) begin
        for (int i = 0; i < N; i++) begin
          clr[i]  = ($urandom_range(0, 99) < 2);
          w_en[i] = ($urandom_range(0, 99) < wp);
          r_en[i] = ($urandom_range(0, 99) < rp);
          din[i]  = W'($urandom);
        end
        tick();
      end
    end
    idle_all();
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_n.md
FIFO_N -- requirements
Module: fifo_n

Interface
REQ-001 SHALL have parameter WIDTH, default 17, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, number of stored words; legal range 1..1024, any integer (not restricted to powers of 2).
REQ-003 SHALL have localparam AW = max(1, clog2(DEPTH)) and localparam CW = clog2(DEPTH+1).
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port clr, input, 1, synchronous flush.
REQ-007 SHALL have port w_en, input, 1, write request.
REQ-008 SHALL have port r_en, input, 1, read request (pop).
REQ-009 SHALL have port data_in, input, WIDTH, write data.
REQ-010 SHALL have port data_out, output, WIDTH, head word when reading, else zero.
REQ-011 SHALL have port full, output, 1, asserted when count == DEPTH.
REQ-012 SHALL have port empty, output, 1, asserted when count == 0.
REQ-013 SHALL have port count, output, CW, current occupancy.
REQ-014 SHALL have port ovf, output, 1, sticky overflow error.
REQ-015 SHALL have port udf, output, 1, sticky underflow error.

Function
REQ-016 SHALL present data_out combinationally as mem[rd_ptr] when r_en=1 and empty=0, and as all-zero otherwise (show-ahead, zero read latency).
REQ-017 SHALL accept a write when w_en=1 and (full=0 or r_en=1): store data_in at wr_ptr and advance wr_ptr.
REQ-018 SHALL accept a read when r_en=1 and empty=0: advance rd_ptr.
REQ-019 SHALL wrap each pointer from DEPTH-1 to 0.
REQ-020 SHALL update count +1 on write-only, -1 on read-only, and leave it unchanged on simultaneous accepted read and write.
REQ-021 SHALL, when full and w_en=r_en=1, accept both; count stays DEPTH and the head word is output that cycle.
REQ-022 SHALL, when empty and w_en=r_en=1, accept the write only; data_out=0, count becomes 1, udf is set.
REQ-023 SHALL drop a write when full=1 and r_en=0; memory and pointers are unchanged and ovf is set.
REQ-024 SHALL set udf on r_en=1 while empty=1; pointers are unchanged.
REQ-025 SHALL hold ovf and udf at 1 until reset or clr.
REQ-026 SHALL, on clr=1, zero pointers, count, ovf and udf at the next edge, ignoring w_en and r_en that cycle; memory contents are left unchanged.
REQ-027 SHALL derive full and empty from registered count only, with no combinational path from w_en or r_en.
REQ-028 SHALL, with DEPTH=1, behave as a single-word register with the flags of REQ-011/012.

Reset
REQ-029 SHALL, on rst_n=0, asynchronously clear pointers, count, ovf, udf and every memory word to 0, giving empty=1, full=0, data_out=0.
REQ-030 SHALL, when reset is asserted mid-operation, discard all stored data; the first read after release returns only data written after release.

Structure
REQ-031 SHALL place the default WIDTH (17), the clog2 helper function and the DEPTH legality limits in shared package fft_pkg.
REQ-032 SHALL implement storage as flip-flops (not inferred RAM) so that the reset clearing in REQ-029 holds.
REQ-033 SHALL instantiate sub-module fifo_ptr twice (write and read): a modulo-DEPTH counter with inc, clr and asynchronous reset.

Verification
REQ-034 SHALL cover: reset, then write 0x00001..0x00005 with DEPTH=32, then read 5 -> data_out 0x00001..0x00005 in order, count 5->0, empty=1.
REQ-035 SHALL cover: with DEPTH=4, fill with 4 words, then write 0x1FFFF with r_en=0 -> full=1, ovf=1, word dropped, later reads return only the 4 original words.
REQ-036 SHALL cover: with DEPTH=4 and the FIFO full, w_en=r_en=1 for 8 cycles -> count stays 4, no ovf, output order preserved across pointer wrap.
REQ-037 SHALL cover: while empty, r_en=1 -> data_out=0, udf=1; then clr=1 -> udf=0, count=0.
REQ-038 SHALL cover: with DEPTH=3, write 2 words, assert rst_n=0 mid-cycle -> empty=1 immediately; after release, write 0x0000A and read it -> 0x0000A.
REQ-039 SHALL cover: DEPTH=1, alternate write/read of 0x15555/0x0AAAA -> full/empty toggle each cycle, data matches.
